// File: rtl/risc16_pkg.sv
// Shared constants and types for the risc16 memory responder.
package risc16_pkg;
  localparam logic [15:0] PROG_START = 16'h000F;
  localparam logic [15:0] IO_BASE = 16'hFF00;
  localparam logic [7:0] IO_STATUS = 8'h00;
  localparam logic [7:0] IO_OUT = 8'h01;
  localparam int STATUS_HALT_BIT = 0;

  typedef enum logic [1:0] {LD_IDLE, LD_HI, LD_LO, LD_WR} ld_state_t;
endpackage

// File: rtl/risc16_prog_loader.sv
// Byte-serial program loader: assembles big-endian words and writes them from START upward.
// Handshake: a byte is taken on a rising clk when load_valid and load_ready are both high.
module risc16_prog_loader
  import risc16_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH),
  parameter logic [15:0] START = PROG_START
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pgm,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [7:0]    load_byte,
  output logic          load_ready,
  output logic [15:0]   load_count,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          clr_halt,
  output ld_state_t     state_dbg
);
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  ld_state_t   state, state_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [15:0] count_q, count_nxt;
  logic [15:0] word_q, word_nxt;
  logic        at_end;

  assign at_end     = {1'b0, addr_q} >= DEPTH_W;
  assign load_count = count_q;
  assign wr_addr    = addr_q[AW-1:0];
  assign wr_data    = word_q;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LD_IDLE;
      addr_q  <= START;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      count_q <= count_nxt;
      word_q  <= word_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    count_nxt  = count_q;
    word_nxt   = word_q;
    wr_en      = 1'b0;
    clr_halt   = 1'b0;
    load_ready = 1'b0;
    case (state)
      LD_HI: begin
        load_ready = 1'b1;
        if (load_valid) begin
          word_nxt[15:8] = load_byte;
          state_nxt      = LD_LO;
        end
      end
      LD_LO: begin
        load_ready = 1'b1;
        if (load_valid) begin
          word_nxt[7:0] = load_byte;
          state_nxt     = LD_WR;
        end
      end
      LD_WR: begin
        // Past the end of RAM the word is dropped but still counted; addr sticks at DEPTH.
        wr_en     = !at_end;
        addr_nxt  = at_end ? addr_q : addr_q + 16'd1;
        count_nxt = count_q + 16'd1;
        state_nxt = LD_HI;
      end
      default: begin
        if (pgm) state_nxt = LD_HI;
      end
    endcase
    // Leaving program mode lets a WR finish above, then parks in IDLE.
    if (!pgm) state_nxt = LD_IDLE;
    if (pgm && load_start) begin
      state_nxt = LD_HI;
      addr_nxt  = START;
      count_nxt = '0;
      clr_halt  = 1'b1;
      wr_en     = 1'b0;
    end
  end
endmodule

// File: rtl/risc16_mem_resp.sv
// Memory-side responder for the risc16 core: RAM, status/halt register, output port and loader.
module risc16_mem_resp #(
  parameter int DEPTH = 1024,
  parameter logic [15:0] PROG_START = risc16_pkg::PROG_START,
  parameter logic [15:0] IO_BASE = risc16_pkg::IO_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pgm,
  input  logic [15:0] pc_in,
  output logic [15:0] ir,
  input  logic [15:0] mem_addr,
  input  logic        mem_rw,
  input  logic [15:0] data_write,
  output logic [15:0] data_in,
  output logic [15:0] status_reg,
  output logic [15:0] out_port,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_ready,
  output logic [15:0] load_count
);
  import risc16_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [15:0]   ram [DEPTH];
  logic          halt;
  logic [15:0]   out_q;
  logic [15:0]   rd_val;
  logic          ld_wr_en, ld_clr_halt;
  logic [AW-1:0] ld_wr_addr;
  logic [15:0]   ld_wr_data;
  ld_state_t     ld_state;
  logic          fetch_in_ram, data_is_io, data_in_ram, core_we;
  logic          io_status_sel, io_out_sel;

  risc16_prog_loader #(.DEPTH(DEPTH), .AW(AW), .START(PROG_START)) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .pgm        (pgm),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .load_count (load_count),
    .wr_en      (ld_wr_en),
    .wr_addr    (ld_wr_addr),
    .wr_data    (ld_wr_data),
    .clr_halt   (ld_clr_halt),
    .state_dbg  (ld_state)
  );

  assign fetch_in_ram  = {1'b0, pc_in} < DEPTH_W;
  assign data_is_io    = mem_addr[15:8] == IO_BASE[15:8];
  assign data_in_ram   = !data_is_io && ({1'b0, mem_addr} < DEPTH_W);
  assign core_we       = mem_rw && !pgm;
  assign io_status_sel = data_is_io && (mem_addr[7:0] == IO_STATUS);
  assign io_out_sel    = data_is_io && (mem_addr[7:0] == IO_OUT);
  assign out_port      = out_q;

  always_comb begin
    status_reg = '0;
    status_reg[STATUS_HALT_BIT] = halt;
  end

  always_comb begin
    rd_val = '0;
    if (io_status_sel) rd_val = status_reg;
    else if (io_out_sel) rd_val = out_q;
    else if (data_in_ram) rd_val = ram[mem_addr[AW-1:0]];
  end

  // Loader owns the write port when active; reads below see the pre-write word.
  always_ff @(posedge clk) begin
    if (ld_wr_en) ram[ld_wr_addr] <= ld_wr_data;
    else if (core_we && data_in_ram) ram[mem_addr[AW-1:0]] <= data_write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir      <= '0;
      data_in <= '0;
      halt    <= 1'b0;
      out_q   <= '0;
    end else begin
      ir <= fetch_in_ram ? ram[pc_in[AW-1:0]] : '0;
      if (!mem_rw) data_in <= rd_val;
      if (ld_clr_halt) halt <= 1'b0;
      else if (core_we && io_status_sel) halt <= data_write[STATUS_HALT_BIT];
      if (core_we && io_out_sel) out_q <= data_write;
    end
  end
endmodule

// File: tb/tb_risc16_mem_resp.sv
// Bench for risc16_mem_resp: loader streams, core access table, halt/IO behaviour, async reset.
module tb_risc16_mem_resp;
  import risc16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pgm;
  logic [15:0] pc_in;
  logic [15:0] ir;
  logic [15:0] mem_addr;
  logic        mem_rw;
  logic [15:0] data_write;
  logic [15:0] data_in;
  logic [15:0] status_reg;
  logic [15:0] out_port;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic [15:0] load_count;

  logic [15:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[13];

  risc16_mem_resp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pgm        (pgm),
    .pc_in      (pc_in),
    .ir         (ir),
    .mem_addr   (mem_addr),
    .mem_rw     (mem_rw),
    .data_write (data_write),
    .data_in    (data_in),
    .status_reg (status_reg),
    .out_port   (out_port),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .load_count (load_count)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!load_ready && n < 8) begin
      tick();
      n++;
    end
    if (!load_ready) begin
      checks++;
      failures++;
      $display("FAIL load_ready_timeout: got 0 expected 1");
    end else begin
      load_valid = 1'b1;
      load_byte  = b;
      tick();
      load_valid = 1'b0;
    end
  endtask

  task automatic core_op(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] expv, input string name);
    logic [15:0] e;
    mem_rw     = rw;
    mem_addr   = addr;
    data_write = wdata;
    if (!rw) exp_q.push_back(expv);
    tick();
    mem_rw = 1'b0;
    if (!rw) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s: got empty queue expected entry", name);
      end else begin
        e = exp_q.pop_front();
        check(name, data_in, e);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0000, 16'h7777, 16'h0000};
    vecs[1]  = '{1'b1, 16'h0020, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1'b0, 16'h0020, 16'h0000, 16'hBEEF};
    vecs[3]  = '{1'b0, 16'h000F, 16'h0000, 16'h1234};
    vecs[4]  = '{1'b0, 16'h0010, 16'h0000, 16'hABCD};
    vecs[5]  = '{1'b1, 16'h0400, 16'h1111, 16'h0000};
    vecs[6]  = '{1'b0, 16'h0400, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h7777};
    vecs[8]  = '{1'b1, 16'hFF01, 16'h00A5, 16'h0000};
    vecs[9]  = '{1'b0, 16'hFF01, 16'h0000, 16'h00A5};
    vecs[10] = '{1'b0, 16'hFF05, 16'h0000, 16'h0000};
    vecs[11] = '{1'b1, 16'hFF00, 16'h0001, 16'h0000};
    vecs[12] = '{1'b0, 16'hFF00, 16'h0000, 16'h0001};

    rst_n = 1'b0; pgm = 1'b0; pc_in = '0; mem_addr = '0; mem_rw = 1'b0;
    data_write = '0; load_start = 1'b0; load_valid = 1'b0; load_byte = '0;
    #12;
    check("rst_ir", ir, 16'h0000);
    check("rst_data_in", data_in, 16'h0000);
    check("rst_status", status_reg, 16'h0000);
    check("rst_out_port", out_port, 16'h0000);
    check("rst_load_ready", 16'(load_ready), 16'h0000);
    check("rst_load_count", load_count, 16'h0000);
    rst_n = 1'b1;
    tick();

    // First program load: 12 34 AB CD
    pgm = 1'b1; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'h12);
    send_byte(8'h34);
    check("wr1_load_ready", 16'(load_ready), 16'h0000);
    send_byte(8'hAB);
    send_byte(8'hCD);
    check("wr2_load_ready", 16'(load_ready), 16'h0000);
    tick();
    check("load_count_2", load_count, 16'd2);
    pgm = 1'b0;
    tick();

    for (int i = 0; i < 13; i++)
      core_op(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
    check("halt_set", status_reg, 16'h0001);
    check("out_port", out_port, 16'h00A5);

    // Fetch path, out-of-range fetch, then read-first on a same-address write
    pc_in = 16'h0020; tick();
    check("fetch_0020", ir, 16'hBEEF);
    pc_in = 16'h0400; tick();
    check("fetch_oob", ir, 16'h0000);
    pc_in = 16'h0020;
    core_op(1'b1, 16'h0020, 16'hCAFE, 16'h0000, "wr_cafe");
    check("read_first_old", ir, 16'hBEEF);
    tick();
    check("read_first_new", ir, 16'hCAFE);

    // load_start clears halt, then partial word discard and byte drop on load_start
    pgm = 1'b1; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("halt_cleared", status_reg, 16'h0000);
    check("count_cleared", load_count, 16'h0000);
    send_byte(8'h55);
    load_start = 1'b1; load_valid = 1'b1; load_byte = 8'h99;
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    tick();
    check("load_count_1", load_count, 16'd1);
    pgm = 1'b0;
    tick();
    core_op(1'b0, 16'h000F, 16'h0000, 16'h1122, "reload_000F");
    core_op(1'b0, 16'h0010, 16'h0000, 16'hABCD, "keep_0010");

    // Core writes are ignored while pgm is high; reads still work
    core_op(1'b1, 16'h0030, 16'h3030, 16'h0000, "wr_3030");
    pgm = 1'b1;
    core_op(1'b1, 16'h0030, 16'h9999, 16'h0000, "wr_9999_pgm");
    core_op(1'b0, 16'h0030, 16'h0000, 16'h3030, "rd_0030_pgm");
    pgm = 1'b0;
    tick();

    // Asynchronous reset while the loader sits in LO
    pgm = 1'b1; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'h77);
    check("in_lo_state", 16'(dut.u_loader.state), 16'(LD_LO));
    #2 rst_n = 1'b0;
    #1;
    check("arst_ir", ir, 16'h0000);
    check("arst_data_in", data_in, 16'h0000);
    check("arst_out_port", out_port, 16'h0000);
    check("arst_load_ready", 16'(load_ready), 16'h0000);
    check("arst_load_count", load_count, 16'h0000);
    #2 rst_n = 1'b1;
    #1;
    check("arst_idle", 16'(dut.u_loader.state), 16'(LD_IDLE));
    pgm = 1'b0;
    tick();
    core_op(1'b0, 16'h000F, 16'h0000, 16'h1122, "after_arst_000F");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/risc16_mem_resp.md
Name: risc16_mem_resp

Overview:
- Memory-side responder for the risc16 core bus: serves instruction fetch (pc_in -> ir) and data load/store (mem_addr, mem_rw, data_write -> data_in).
- Owns program/data RAM, the status register (halt bit) fed back to the core, and a memory-mapped output port.
- Contains a byte-serial program loader that fills RAM from PROG_START while pgm is high.

Parameters:
- DEPTH, 1024: RAM words; addresses >= DEPTH below the IO page read 0 and ignore writes.
- PROG_START, 16'h000F: first load address; matches core reset PC.
- IO_BASE, 16'hFF00: base of memory-mapped IO page.

Ports:
- clk  in  1  bus clock (core mem_clk).
- rst_n  in  1  asynchronous, active-low reset.
- pgm  in  1  program mode; core is frozen, loader owns RAM write port.
- pc_in  in  16  fetch address from core.
- ir  out  16  fetched instruction word.
- mem_addr  in  16  data address from core.
- mem_rw  in  1  1 = write, 0 = read.
- data_write  in  16  store data from core.
- data_in  out  16  load data to core.
- status_reg  out  16  bit0 = halt; bits 15:1 read 0.
- out_port  out  16  IO output register.
- load_start  in  1  pulse; restarts loader at PROG_START.
- load_valid  in  1  load_byte valid.
- load_byte  in  8  program byte, high byte of each word first.
- load_ready  out  1  loader accepts byte this cycle.
- load_count  out  16  words written since last load_start.

Behaviour:
- Reset (rst_n low, async): ir=0, data_in=0, status_reg=0, out_port=0, load_ready=0, load_count=0, loader state IDLE, load address=PROG_START. RAM contents are not reset.
- Fetch: ir <= RAM[pc_in] registered on every rising clk. Latency is 1 cycle. pc_in >= DEPTH returns 0.
- Data read (mem_rw=0): data_in <= read value registered on every rising clk. Latency is 1 cycle.
  - RAM: RAM[mem_addr].
  - IO_BASE+0: status_reg.
  - IO_BASE+1: out_port.
  - Any other IO address: 0.
- Data write (mem_rw=1, pgm=0), committed on rising clk:
  - RAM: RAM[mem_addr] <= data_write.
  - IO_BASE+0: halt <= data_write[0].
  - IO_BASE+1: out_port <= data_write.
- Read-during-write to the same RAM address returns the old word (read-first).
- While pgm=1, core writes are ignored; fetch and read paths keep operating.
- Loader FSM, states IDLE, HI, LO, WR:
  - IDLE: load_ready=0. Go to HI when pgm=1.
  - HI: load_ready=1. On load_valid, latch byte as word[15:8] and go to LO.
  - LO: load_ready=1. On load_valid, latch byte as word[7:0] and go to WR.
  - WR: load_ready=0. RAM[addr] <= word; addr += 1; load_count += 1; go to HI.
- Throughput: at most one word per 3 cycles.
- load_start (any state, pgm=1): addr=PROG_START, load_count=0, halt cleared, state HI, any partial word discarded. load_start has priority over a same-cycle load_valid; that byte is dropped.
- pgm falling: state returns to IDLE next cycle; a pending half word is discarded; a WR in progress completes first.
- Address wrap: once addr reaches DEPTH, WR does not write but load_count still increments. addr saturates at DEPTH.
- Halt: set only by a core write; cleared by reset, load_start, or a core write of 0.
- Mid-operation rst_n assertion aborts the loader immediately. Its only RAM effect is a possibly lost in-flight write.

Decomposition:
- Shared package risc16_pkg: PROG_START, IO_BASE, IO offsets (IO_STATUS=0, IO_OUT=1), STATUS_HALT_BIT=0, loader state enum.
- One sub-module, risc16_prog_loader: FSM, address, count and handshake. It outputs a write enable, address and data into the RAM write-port mux.

Test Plan:
- Reset then pgm=1 with load_start, stream bytes 12 34 AB CD -> RAM[0x000F]=0x1234, RAM[0x0010]=0xABCD, load_count=2, load_ready low in each WR cycle.
- Write 0xBEEF to address 0x0020 (mem_rw=1), then read it -> data_in=0xBEEF one cycle after the read address is applied; pc_in=0x0020 gives ir=0xBEEF one cycle later.
- Write 0x0001 to 0xFF00 -> status_reg=0x0001. Pulse load_start with pgm=1 -> status_reg=0x0000.
- Send one byte 0x55 then load_start, then 0x11 0x22 -> RAM[0x000F]=0x1122 and load_count=1 (partial word discarded).
- With pgm=1, core write 0x9999 to 0x0030 -> RAM[0x0030] unchanged. Write 0x00A5 to 0xFF01 with pgm=0 -> out_port=0x00A5; a read of 0xFF05 returns 0.
- Assert rst_n low during the loader LO state -> all outputs are at reset values immediately (async), and the loader is IDLE after release.
